mbist_mem_wrapper: RTL and testbench

- 256x4 memory under test with a built-in fault injector.
- Sits directly downstream of the March LR BIST controller: consumes its address, write data and write enable, and returns read data to its dat_in.
- A 2:1 mux selects between the BIST path and the functional path.
- Injectable single-cell faults (stuck-at-0, stuck-at-1, up-transition, inversion coupling) let the BIST controller be exercised against known defects.

---
 rtl/mbist_pkg.sv | 17 +
 rtl/mbist_fault_inj.sv | 73 +++++++
 rtl/mbist_mem_wrapper.sv | 108 ++++++++++
 tb/tb_mbist_mem_wrapper.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/mbist_pkg.sv
// mbist_pkg: shared encodings and default geometry for the MBIST memory wrapper
// Contents: fault-type encoding (fault_e), wrapper state encoding (state_e),
// default address/data widths shared with the March controllers.
package mbist_pkg;
    localparam int AW_DEF = 8;
    localparam int DW_DEF = 4;
    typedef enum logic [1:0] {
        FT_SA0 = 2'b00,
        FT_SA1 = 2'b01,
        FT_TFU = 2'b10,
        FT_CF  = 2'b11
    } fault_e;
    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;
endpackage

// File: rtl/mbist_fault_inj.sv
// mbist_fault_inj: latched single-cell fault config, write-data override and read-data mask
// Ports:
//   clk, rst                       clock, async active-high reset (clears config)
//   fi_load_i..fi_agg_addr_i       fault config, sampled on fi_load_i
//   active_i                       injection allowed (array in READY)
//   addr_i, we_i, din_i            selected port access this cycle
//   mem_i                          raw stored word at addr_i
//   wdata_o                        word to store (TF-up applied)
//   rdata_o                        word to read out (stuck-at applied)
//   flip_o, flip_addr_o, flip_mask_o  coupling victim inversion request
module mbist_fault_inj
    import mbist_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF,
    parameter int BW = $clog2(DW)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fi_load_i,
    input  logic          fi_en_i,
    input  logic [1:0]    fi_type_i,
    input  logic [AW-1:0] fi_addr_i,
    input  logic [BW-1:0] fi_bit_i,
    input  logic [AW-1:0] fi_agg_addr_i,
    input  logic          active_i,
    input  logic [AW-1:0] addr_i,
    input  logic          we_i,
    input  logic [DW-1:0] din_i,
    input  logic [DW-1:0] mem_i,
    output logic [DW-1:0] wdata_o,
    output logic [DW-1:0] rdata_o,
    output logic          flip_o,
    output logic [AW-1:0] flip_addr_o,
    output logic [DW-1:0] flip_mask_o
);
    logic          en_q;
    fault_e        type_q;
    logic [AW-1:0] vaddr_q;
    logic [AW-1:0] agg_q;
    logic [BW-1:0] bit_q;
    logic [DW-1:0] bmask;
    logic          hit_v;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q    <= 1'b0;
            type_q  <= FT_SA0;
            vaddr_q <= '0;
            agg_q   <= '0;
            bit_q   <= '0;
        end else if (fi_load_i) begin
            en_q    <= fi_en_i;
            type_q  <= fault_e'(fi_type_i);
            vaddr_q <= fi_addr_i;
            agg_q   <= fi_agg_addr_i;
            bit_q   <= fi_bit_i;
        end
    end

    assign bmask = DW'(1) << bit_q;
    assign hit_v = active_i && en_q && addr_i == vaddr_q;

    assign rdata_o = (hit_v && type_q == FT_SA0) ? (mem_i & ~bmask) :
                     (hit_v && type_q == FT_SA1) ? (mem_i | bmask) : mem_i;
    // A victim bit already at 0 cannot be raised; all other bits pass through.
    assign wdata_o = (hit_v && type_q == FT_TFU) ? (din_i & (mem_i | ~bmask)) : din_i;
    // Aggressor bit rising 0->1 inverts the victim bit; self-coupling is inert.
    assign flip_o  = active_i && en_q && type_q == FT_CF && we_i &&
                     addr_i == agg_q && agg_q != vaddr_q && |(~mem_i & din_i & bmask);
    assign flip_addr_o = vaddr_q;
    assign flip_mask_o = bmask;
endmodule

// File: rtl/mbist_mem_wrapper.sv
// mbist_mem_wrapper: 256x4 memory under test with init sweep, BIST/functional mux and fault injector
// Ports:
//   clk, rst                         clock, async active-high reset
//   bist_sel                         1 = BIST port drives the array, 0 = functional port
//   bist_addr/bist_din/bist_we       BIST access
//   func_addr/func_din/func_we       functional access
//   dout                             registered read data, 1-cycle latency, read-first
//   ready                            high once the zeroing sweep has completed
//   fi_load..fi_agg_addr             fault injector configuration
module mbist_mem_wrapper
    import mbist_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bist_sel,
    input  logic [AW-1:0]         bist_addr,
    input  logic [DW-1:0]         bist_din,
    input  logic                  bist_we,
    input  logic [AW-1:0]         func_addr,
    input  logic [DW-1:0]         func_din,
    input  logic                  func_we,
    output logic [DW-1:0]         dout,
    output logic                  ready,
    input  logic                  fi_load,
    input  logic                  fi_en,
    input  logic [1:0]            fi_type,
    input  logic [AW-1:0]         fi_addr,
    input  logic [$clog2(DW)-1:0] fi_bit,
    input  logic [AW-1:0]         fi_agg_addr
);
    state_e        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [DW-1:0] dout_q;
    logic [DW-1:0] mem_q [2**AW];
    logic          active;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_din;
    logic          sel_we;
    logic [DW-1:0] fi_wdata;
    logic [DW-1:0] fi_rdata;
    logic          flip;
    logic [AW-1:0] flip_addr;
    logic [DW-1:0] flip_mask;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_INIT;
            ptr_q   <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            dout_q  <= active ? fi_rdata : '0;
        end
    end

    always_comb begin
        state_d = (state_q == ST_INIT && &ptr_q) ? ST_READY : state_q;
        ptr_d   = (state_q == ST_INIT) ? ptr_q + 1'b1 : ptr_q;
    end

    assign active   = state_q == ST_READY;
    assign sel_addr = bist_sel ? bist_addr : func_addr;
    assign sel_din  = bist_sel ? bist_din  : func_din;
    assign sel_we   = bist_sel ? bist_we   : func_we;

    // The sweep owns the array until READY; port enables are ignored meanwhile.
    assign wr_en   = active ? sel_we   : 1'b1;
    assign wr_addr = active ? sel_addr : ptr_q;
    assign wr_data = active ? fi_wdata : '0;

    // Victim and aggressor addresses always differ when flip is set, so the
    // two updates never target the same word.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_addr] <= wr_data;
        if (flip) mem_q[flip_addr] <= mem_q[flip_addr] ^ flip_mask;
    end

    mbist_fault_inj #(.AW(AW), .DW(DW)) u_fi (
        .clk          (clk),
        .rst          (rst),
        .fi_load_i    (fi_load),
        .fi_en_i      (fi_en),
        .fi_type_i    (fi_type),
        .fi_addr_i    (fi_addr),
        .fi_bit_i     (fi_bit),
        .fi_agg_addr_i(fi_agg_addr),
        .active_i     (active),
        .addr_i       (sel_addr),
        .we_i         (sel_we),
        .din_i        (sel_din),
        .mem_i        (mem_q[sel_addr]),
        .wdata_o      (fi_wdata),
        .rdata_o      (fi_rdata),
        .flip_o       (flip),
        .flip_addr_o  (flip_addr),
        .flip_mask_o  (flip_mask)
    );

    assign dout  = dout_q;
    assign ready = active;
endmodule

// File: tb/tb_mbist_mem_wrapper.sv
// tb_mbist_mem_wrapper: directed stimulus, behavioural memory model compared every cycle plus literal checks
module tb_mbist_mem_wrapper;
    logic       clk = 0, rst = 0;
    logic       bist_sel = 0, bist_we = 0, func_we = 0;
    logic [7:0] bist_addr = 0, func_addr = 0, fi_addr = 0, fi_agg_addr = 0;
    logic [3:0] bist_din = 0, func_din = 0, dout;
    logic       ready, fi_load = 0, fi_en = 0;
    logic [1:0] fi_type = 0, fi_bit = 0;
    int         n_chk = 0, n_pass = 0, cyc;

    always #5 clk = ~clk;

    mbist_mem_wrapper dut (
        .clk(clk), .rst(rst), .bist_sel(bist_sel), .bist_addr(bist_addr),
        .bist_din(bist_din), .bist_we(bist_we), .func_addr(func_addr),
        .func_din(func_din), .func_we(func_we), .dout(dout), .ready(ready),
        .fi_load(fi_load), .fi_en(fi_en), .fi_type(fi_type), .fi_addr(fi_addr),
        .fi_bit(fi_bit), .fi_agg_addr(fi_agg_addr)
    );

    // Behavioural model: zeroing countdown, plain array, fault rules applied directly.
    logic [3:0] m_mem [256];
    int         m_cnt = 0;
    logic       m_ready = 0;
    logic [3:0] m_dout = 0;
    logic       m_en = 0;
    logic [1:0] m_type = 0;
    logic [7:0] m_va = 0, m_ag = 0, m_a;
    logic [1:0] m_b = 0;
    logic [3:0] m_d, m_old, m_new;
    logic       m_w;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt = 0; m_ready = 0; m_dout = 0; m_en = 0;
            m_type = 0; m_va = 0; m_ag = 0; m_b = 0;
        end else begin
            if (!m_ready) begin
                m_mem[m_cnt] = 4'h0;
                m_cnt++;
                m_ready = (m_cnt == 256);
                m_dout = 4'h0;
            end else begin
                m_a = bist_sel ? bist_addr : func_addr;
                m_d = bist_sel ? bist_din : func_din;
                m_w = bist_sel ? bist_we : func_we;
                m_old = m_mem[m_a];
                m_dout = m_old;
                if (m_en && m_a == m_va && m_type == 2'b00) m_dout[m_b] = 1'b0;
                if (m_en && m_a == m_va && m_type == 2'b01) m_dout[m_b] = 1'b1;
                if (m_w) begin
                    m_new = m_d;
                    if (m_en && m_type == 2'b10 && m_a == m_va && !m_old[m_b] && m_d[m_b])
                        m_new[m_b] = 1'b0;
                    m_mem[m_a] = m_new;
                    if (m_en && m_type == 2'b11 && m_a == m_ag && m_ag != m_va && !m_old[m_b] && m_d[m_b])
                        m_mem[m_va][m_b] = ~m_mem[m_va][m_b];
                end
            end
            if (fi_load) begin
                m_en = fi_en; m_type = fi_type; m_va = fi_addr; m_b = fi_bit; m_ag = fi_agg_addr;
            end
        end
    end

    task automatic cmp(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    always @(negedge clk) begin
        #1;
        cmp("model_ready", int'(ready), int'(m_ready));
        cmp("model_dout", int'(dout), int'(m_dout));
    end

    // Drive the selected port; the other port carries a conflicting write that must be ignored.
    task automatic op(input logic sel, input logic [7:0] a, input logic [3:0] d, input logic we);
        @(negedge clk);
        fi_load = 0;
        bist_sel = sel;
        bist_addr = sel ? a : ~a;  bist_din = sel ? d : ~d;  bist_we = sel ? we : 1'b1;
        func_addr = sel ? ~a : a;  func_din = sel ? ~d : d;  func_we = sel ? 1'b1 : we;
    endtask

    task automatic load(input logic en, input logic [1:0] t, input logic [7:0] va,
                        input logic [1:0] b, input logic [7:0] ag);
        @(negedge clk);
        fi_load = 1; fi_en = en; fi_type = t; fi_addr = va; fi_bit = b; fi_agg_addr = ag;
        bist_we = 0; func_we = 0;
    endtask

    task automatic chk(input string nm, input logic [3:0] exp);
        @(posedge clk);
        #1;
        cmp(nm, int'(dout), int'(exp));
    endtask

    task automatic wait_ready(output int c);
        c = 0;
        while (!ready && c < 300) begin
            @(posedge clk);
            #1;
            c++;
        end
    endtask

    initial begin
        #1 rst = 1;
        repeat (3) @(negedge clk);
        bist_sel = 1; bist_we = 1; bist_din = 4'hF; bist_addr = 8'h00;
        func_we = 1; func_din = 4'hF; func_addr = 8'h80;
        rst = 0;
        wait_ready(cyc);
        cmp("init_len", cyc, 256);

        op(0, 8'h00, 4'h0, 0); chk("rd0", 4'h0);
        op(0, 8'h80, 4'h0, 0); chk("rd128", 4'h0);
        op(0, 8'hFF, 4'h0, 0); chk("rd255", 4'h0);

        op(1, 8'h05, 4'hA, 1);
        op(1, 8'h05, 4'h0, 0); chk("wr_rd", 4'hA);
        op(1, 8'h05, 4'h3, 1); chk("read_first_old", 4'hA);
        op(1, 8'h05, 4'h0, 0); chk("read_first_new", 4'h3);

        load(1, 2'b01, 8'h10, 2'd2, 8'h00);
        op(1, 8'h10, 4'h0, 1);
        op(1, 8'h10, 4'h0, 0); chk("sa1", 4'h4);
        load(0, 2'b01, 8'h10, 2'd2, 8'h00);
        op(1, 8'h10, 4'h0, 0); chk("sa1_off", 4'h0);

        load(1, 2'b00, 8'h05, 2'd0, 8'h00);
        op(0, 8'h05, 4'h0, 0); chk("sa0", 4'h2);

        load(1, 2'b10, 8'h20, 2'd0, 8'h00);
        op(1, 8'h20, 4'hF, 1);
        op(1, 8'h20, 4'h0, 0); chk("tfu_up", 4'hE);
        op(1, 8'h20, 4'h0, 1);
        op(1, 8'h20, 4'h0, 0); chk("tfu_down", 4'h0);

        load(1, 2'b11, 8'h30, 2'd1, 8'h31);
        op(1, 8'h30, 4'h0, 1);
        op(1, 8'h31, 4'h2, 1);
        op(1, 8'h30, 4'h0, 0); chk("cf_flip", 4'h2);
        op(0, 8'h31, 4'h2, 1);
        op(1, 8'h30, 4'h0, 0); chk("cf_hold", 4'h2);
        op(0, 8'h31, 4'h0, 1);
        op(0, 8'h31, 4'h2, 1);
        op(0, 8'h30, 4'h0, 0); chk("cf_flip2", 4'h0);

        op(1, 8'h40, 4'h9, 1);
        op(1, 8'h40, 4'h0, 0); chk("pre_rst", 4'h9);
        @(negedge clk); rst = 1; #1;
        cmp("bist_rst_ready", int'(ready), 0);
        cmp("bist_rst_dout", int'(dout), 0);
        @(negedge clk); rst = 0;
        wait_ready(cyc);
        cmp("bist_rst_len", cyc, 256);
        op(1, 8'h40, 4'h0, 0); chk("swept", 4'h0);
        op(1, 8'h30, 4'h0, 0); chk("cfg_cleared", 4'h0);

        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0;
        repeat (100) @(posedge clk);
        @(negedge clk); rst = 1; #1;
        cmp("init_rst_ready", int'(ready), 0);
        cmp("init_rst_dout", int'(dout), 0);
        @(negedge clk); rst = 0;
        wait_ready(cyc);
        cmp("init_rst_len", cyc, 256);
        op(0, 8'h05, 4'h0, 0); chk("post_rst_rd", 4'h0);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
